// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control FSM driving datapath muxes, enables and ALU control
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB   = 4'd4,  MEMWR  = 4'd5,  RTYPEEX = 4'd6, ALUWB  = 4'd7,
        BEQEX   = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JEX    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     st;
    logic [2:0] funct_alu;
    logic       funct_ok;
    logic       op_ok;
    logic       pcwrite, branch;
    logic       irwrite_s, regwrite_s, memwrite_s, illegal_s;

    assign state = st;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
            default:                                       op_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= FETCH;
        end else begin
            case (st)
                FETCH:  st <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: st <= MEMADR;
                        OP_RTYPE:     st <= RTYPEEX;
                        OP_BEQ:       st <= BEQEX;
                        OP_ADDI:      st <= ADDIEX;
                        OP_J:         st <= JEX;
                        default:      st <= FETCH;
                    endcase
                end
                MEMADR:  st <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   st <= MEMWB;
                RTYPEEX: st <= funct_ok ? ALUWB : FETCH;
                ADDIEX:  st <= ADDIWB;
                default: st <= FETCH;
            endcase
        end
    end

    // Moore decode of the current state; only illegal and alucontrol also look at op/funct
    always_comb begin
        iord       = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite_s = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 3'b010;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal_s  = 1'b0;
        case (st)
            FETCH: begin
                alusrcb   = 2'b01;
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
            end
            DECODE: begin
                alusrcb   = 2'b11;
                illegal_s = ~op_ok;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct_ok ? funct_alu : 3'b010;
                illegal_s  = ~funct_ok;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                branch     = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: regwrite_s = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes are held off for the whole reset pulse, not just until the next edge
    assign pcen     = ~reset & (pcwrite | (branch & zero));
    assign irwrite  = ~reset & irwrite_s;
    assign regwrite = ~reset & regwrite_s;
    assign memwrite = ~reset & memwrite_s;
    assign illegal  = ~reset & illegal_s;
endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized instruction-level check of mc_controller against a reference model
module tb_mc_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       pcen, illegal;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc),
        .pcen(pcen), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_RTYPE = 6, S_ALUWB = 7, S_BEQ = 8, S_ADDI = 9,
                   S_ADDIWB = 10, S_JEX = 11;

    typedef enum int { K_LW, K_SW, K_RT, K_BEQ, K_ADDI, K_J, K_BADOP, K_BADFN } kind_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic kind_t classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h04: return K_BEQ;
            6'h08: return K_ADDI;
            6'h02: return K_J;
            6'h00: begin
                case (f)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2a: return K_RT;
                    default:                           return K_BADFN;
                endcase
            end
            default: return K_BADOP;
        endcase
    endfunction

    function automatic void state_path(input kind_t k, output int q[$]);
        case (k)
            K_LW:    q = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
            K_SW:    q = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
            K_RT:    q = '{S_FETCH, S_DECODE, S_RTYPE, S_ALUWB};
            K_ADDI:  q = '{S_FETCH, S_DECODE, S_ADDI, S_ADDIWB};
            K_BEQ:   q = '{S_FETCH, S_DECODE, S_BEQ};
            K_J:     q = '{S_FETCH, S_DECODE, S_JEX};
            K_BADOP: q = '{S_FETCH, S_DECODE};
            default: q = '{S_FETCH, S_DECODE, S_RTYPE};
        endcase
    endfunction

    task automatic check_cycle(input int s, input kind_t k);
        logic [1:0] e_srcb, e_pcsrc;
        logic [2:0] e_alu;
        e_srcb  = (s == S_FETCH) ? 2'b01 : (s == S_DECODE) ? 2'b11 :
                  (s == S_MEMADR || s == S_ADDI) ? 2'b10 : 2'b00;
        e_alu   = (s == S_RTYPE) ? ref_alu(funct) : (s == S_BEQ) ? 3'b110 : 3'b010;
        e_pcsrc = (s == S_BEQ) ? 2'b01 : (s == S_JEX) ? 2'b10 : 2'b00;
        check("state", 32'(state), 32'(s));
        check("iord", 32'(iord), 32'(s == S_MEMRD || s == S_MEMWR));
        check("memwrite", 32'(memwrite), 32'(s == S_MEMWR));
        check("irwrite", 32'(irwrite), 32'(s == S_FETCH));
        check("regdst", 32'(regdst), 32'(s == S_ALUWB));
        check("memtoreg", 32'(memtoreg), 32'(s == S_MEMWB));
        check("regwrite", 32'(regwrite), 32'(s == S_MEMWB || s == S_ALUWB || s == S_ADDIWB));
        check("alusrca", 32'(alusrca), 32'(s == S_MEMADR || s == S_RTYPE || s == S_BEQ || s == S_ADDI));
        check("alusrcb", 32'(alusrcb), 32'(e_srcb));
        check("alucontrol", 32'(alucontrol), 32'(e_alu));
        check("pcsrc", 32'(pcsrc), 32'(e_pcsrc));
        check("pcen", 32'(pcen), 32'(s == S_FETCH || s == S_JEX || (s == S_BEQ && zero)));
        check("illegal", 32'(illegal),
              32'((s == S_DECODE && k == K_BADOP) || (s == S_RTYPE && k == K_BADFN)));
        check("one_write", 32'(int'(regwrite) + int'(memwrite) + int'(irwrite) <= 1), 32'(1));
    endtask

    // abort_at >= 0 asserts reset right after that cycle of the instruction has been checked
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int abort_at);
        int    path[$];
        kind_t k;
        k = classify(o, f);
        state_path(k, path);
        for (int i = 0; i < path.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                op    = o;
                funct = f;
            end
            zero = 1'($urandom_range(0, 1));
            #1;
            check_cycle(path[i], k);
            if (i == abort_at) begin
                #1 reset = 1'b1;
                #1;
                check("rst_state", 32'(state), 32'(S_FETCH));
                check("rst_memwrite", 32'(memwrite), 32'(0));
                check("rst_pcen", 32'(pcen), 32'(0));
                check("rst_irwrite", 32'(irwrite), 32'(0));
                check("rst_alusrcb", 32'(alusrcb), 32'(2'b01));
                @(posedge clk);
                #2 reset = 1'b0;
                return;
            end
        end
    endtask

    task automatic run_beq(input logic z);
        @(negedge clk); op = 6'h04; funct = 6'h00; zero = 1'b0;
        #1 check_cycle(S_FETCH, K_BEQ);
        @(negedge clk); #1 check_cycle(S_DECODE, K_BEQ);
        @(negedge clk); zero = z;
        #1 check_cycle(S_BEQ, K_BEQ);
        check("beq_pcen", 32'(pcen), 32'(z));
    endtask

    logic [5:0] legal_ops [6]  = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02};
    logic [5:0] legal_fns [5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

    initial begin
        logic [5:0] o, f;
        reset = 1'b1; op = 6'h00; funct = 6'h20; zero = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(state), 32'(S_FETCH));
        check("reset_pcen", 32'(pcen), 32'(0));
        check("reset_irwrite", 32'(irwrite), 32'(0));
        check("reset_alusrcb", 32'(alusrcb), 32'(2'b01));
        @(posedge clk);
        #2 reset = 1'b0;

        run_instr(6'h2b, 6'h00, 3);
        run_instr(6'h23, 6'h00, -1);
        run_instr(6'h00, 6'h2a, -1);
        run_beq(1'b1);
        run_beq(1'b0);
        run_instr(6'h02, 6'h00, -1);
        run_instr(6'h2a, 6'h00, -1);
        run_instr(6'h00, 6'h07, -1);

        for (int n = 0; n < 300; n++) begin
            o = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
            f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 4)];
            run_instr(o, f, ($urandom_range(0, 19) == 0) ? 1 : -1);
        end

        @(negedge clk); #1;
        check("final_fetch", 32'(state), 32'(S_FETCH));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle MIPS control unit that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It decodes `op`/`funct` from the instruction register and drives the datapath muxes and write enables. It also generates the 3-bit `alucontrol` word consumed by the ALU, and takes the ALU `zero` flag back to resolve branches. Moore FSM with one Mealy term (`pcen`); it replaces the single-cycle combinational controller in the multicycle datapath.

## Interface
- No parameters; state encoding fixed (below).
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high.
- `op` input 6: instruction[31:26] from instruction register.
- `funct` input 6: instruction[5:0].
- `zero` input 1: ALU Z flag, valid in the cycle it is sampled.
- `iord` output 1: memory address mux, 0 = PC, 1 = ALUOut.
- `memwrite` output 1: data memory write enable.
- `irwrite` output 1: instruction register load.
- `regdst` output 1: write register, 0 = rt, 1 = rd.
- `memtoreg` output 1: writeback data, 0 = ALUOut, 1 = memory data.
- `regwrite` output 1: register file write enable.
- `alusrca` output 1: SrcA, 0 = PC, 1 = reg A.
- `alusrcb` output 2: SrcB, 00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `alucontrol` output 3: ALU F (AND 000, OR 001, ADD 010, SUB 110, SLT 111).
- `pcsrc` output 2: PC source, 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pcen` output 1: PC load = pcwrite | (branch & zero).
- `illegal` output 1: one-cycle pulse on an unsupported op or funct.
- `state` output 4: current state, for debug and verification.

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, ALUWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12–15 are unreachable; if entered, go to FETCH with all enables 0.
- Output defaults: all 0, `alucontrol`=010, `alusrcb`=00, `pcsrc`=00.
- Per-state outputs (only non-defaults listed):
  - FETCH: `alusrcb`=01, `irwrite`=1, `pcwrite`=1.
  - DECODE: `alusrcb`=11.
  - MEMADR: `alusrca`=1, `alusrcb`=10.
  - MEMRD: `iord`=1.
  - MEMWB: `memtoreg`=1, `regwrite`=1.
  - MEMWR: `iord`=1, `memwrite`=1.
  - RTYPEEX: `alusrca`=1, `alucontrol` from funct.
  - ALUWB: `regdst`=1, `regwrite`=1.
  - BEQEX: `alusrca`=1, `alucontrol`=110, `pcsrc`=01, `branch`=1.
  - ADDIEX: `alusrca`=1, `alusrcb`=10.
  - ADDIWB: `regwrite`=1.
  - JEX: `pcsrc`=10, `pcwrite`=1.
- Funct decode: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
- Transitions:
  - FETCH → DECODE.
  - DECODE by op:
    - 100011 (lw) and 101011 (sw) → MEMADR.
    - 000000 → RTYPEEX.
    - 000100 → BEQEX.
    - 001000 → ADDIEX.
    - 000010 → JEX.
    - Any other op → FETCH with `illegal`=1.
  - MEMADR → MEMRD if op = lw, else MEMWR.
  - MEMRD → MEMWB.
  - RTYPEEX → ALUWB if funct is supported; otherwise → FETCH with `illegal`=1 and `alucontrol`=010.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, ALUWB, BEQEX, ADDIWB, JEX → FETCH.
- `pcen` is combinational: it follows `zero` within BEQEX and is independent of `zero` in every other state.

## Timing
- Asynchronous reset: `state` goes to FETCH immediately.
- While `reset`=1, force `pcen`, `irwrite`, `regwrite`, `memwrite` and `illegal` to 0. The other outputs show the FETCH values.
- After reset deasserts, the first rising edge performs the FETCH writes (PC+4 into PC, memory word into IR).
- Reset asserted mid-instruction: abort at once, no pending write is issued, restart from FETCH.
- `op`/`funct` are sampled only for the next-state and funct decode. They are held stable by the IR because `irwrite`=1 only in FETCH.
- Latency in cycles per instruction:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Illegal op 2; illegal funct 3.
- At most one of `regwrite`, `memwrite`, `irwrite` is high in any cycle. `pcen` can coincide only with `irwrite` (FETCH).

## Test plan
- Reset asserted mid-cycle with state=MEMWR → `state`=0 immediately; `memwrite`=0 with no clock edge; after release, `state` sequence 0,1,...
- op=100011 → `state` 0,1,2,3,4,0; `iord`=1 in state 3; `regwrite`=1 and `memtoreg`=1 in state 4.
- op=000000, funct=101010 → states 0,1,6,7,0; `alucontrol`=111 in state 6; `regdst`=1 and `regwrite`=1 in state 7.
- op=000100 in BEQEX: `zero`=1 → `pcen`=1 and `pcsrc`=01; `zero`=0 → `pcen`=0; next state is 0 either way.
- op=000010 → states 0,1,11,0 with `pcsrc`=10 and `pcen`=1 in state 11. op=101010 (unsupported) → `illegal` pulses in state 1, next state 0.
- op=000000, funct=000111 → `illegal`=1 in state 6, `regwrite` never asserted, returns to 0 after 3 cycles.
